vga_scan_out: RTL and testbench
===============================

# vga_scan_out

Display scan generator and output stage: the producing end of the draw-coordinate / pixel-colour interface consumed by every sprite and background draw block. It runs free-running horizontal and vertical counters on `pixclk`, broadcasts them as `draw_x`/`draw_y`, and collects the composited 12-bit pixel the draw pipeline returns `PIPE_DELAY` cycles later. It then drives the VGA pins with sync, blanking and mask-colour substitution aligned to that latency. It also provides frame-level timing (`frame_start`, `vblank`) to the game-state logic.

## Interface
- `H_ACTIVE`, 1024, visible pixels per line
- `H_FP`, 24, horizontal front porch (clocks)
- `H_SYNC`, 136, hsync pulse width (clocks)
- `H_BP`, 160, horizontal back porch (clocks); line total = 1344
- `V_ACTIVE`, 768, visible lines
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 6, vsync pulse width (lines)
- `V_BP`, 29, vertical back porch (lines); frame total = 806
- `PIPE_DELAY`, 2, clocks from `draw_x`/`draw_y` to the matching `pixel_rgb`; legal 1..7
- `MASK_RGB`, 12'h0F0, transparent-key colour (same value as `` `MASK ``)
- `BG_RGB`, 12'h000, colour driven when `pixel_rgb` equals `MASK_RGB`
- `pixclk  in  1  pixel clock, 65 MHz`
- `rst_n  in  1  asynchronous, active-low reset`
- `pixel_rgb  in  12  composited colour {R[3:0],G[3:0],B[3:0]} for coordinates issued PIPE_DELAY cycles earlier`
- `draw_x  out  11  current horizontal count, 0..1343`
- `draw_y  out  10  current vertical count, 0..805`
- `vga_rgb  out  12  pin colour; 0 when blanked`
- `vga_hsync  out  1  horizontal sync, active low`
- `vga_vsync  out  1  vertical sync, active low`
- `vblank  out  1  high while draw_y >= V_ACTIVE`
- `frame_start  out  1  one-cycle pulse on frame wrap`

## Operation
- `draw_x` increments every clock. At 1343 it wraps to 0, and `draw_y` increments; at `draw_y` = 805 it wraps to 0. Counters are registers and are exposed directly.
- Raw sync/active terms are computed from the counters:
  - `hs_raw` = low for `draw_x` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [1048, 1183].
  - `vs_raw` = low for `draw_y` in [771, 776].
  - `act_raw` = `draw_x` < 1024 && `draw_y` < 768.
- `hs_raw`, `vs_raw` and `act_raw` pass through a `PIPE_DELAY`-stage shift register. The tap at depth `PIPE_DELAY` is aligned with `pixel_rgb`.
- Output register, updated every clock:
  - if delayed active: `vga_rgb` <= (`pixel_rgb` == `MASK_RGB`) ? `BG_RGB` : `pixel_rgb`.
  - else: `vga_rgb` <= 0.
  - `vga_hsync` and `vga_vsync` <= delayed sync terms.
- `vblank` is registered and equals (`draw_y` >= 768) in the same cycle as the counters; it is not delayed.
- `frame_start` is registered. It is high for exactly the one cycle in which (`draw_x`, `draw_y`) = (0, 0) after a wrap from (1343, 805). It is not asserted for the first (0, 0) after reset.
- Arithmetic: compare in native widths. All parameter sums are precomputed as localparams of 11 bits (H) and 10 bits (V).

## Timing
- Reset (`rst_n` low, async):
  - `draw_x`=0, `draw_y`=0.
  - `vga_rgb`=0, `vga_hsync`=1, `vga_vsync`=1.
  - `vblank`=0, `frame_start`=0.
  - All delay stages cleared to inactive/sync-deasserted.
- Reset release: counting begins on the first `pixclk` rising edge after `rst_n` rises. Outputs stay blanked and deasserted until real data reaches the delay tap.
- Latency: counter value to pins = `PIPE_DELAY` + 1 clocks. Sync and colour at the pins are always mutually aligned.
- Reset mid-frame: all outputs return to reset values immediately, with no partial sync pulse held. The scan restarts at (0, 0).
- Wrap boundaries:
  - (1343, y) -> (0, y+1).
  - (1343, 805) -> (0, 0) with `frame_start`.
  - No skipped or repeated counts.
- `pixel_rgb` is sampled every cycle but used only when the delayed active bit is set. Values outside the active region never reach the pins.

## Test plan
- Reset: hold `rst_n` low with `pixel_rgb`=12'hFFF -> all outputs at reset values. After release, `draw_x` reads 0, 1, 2 on consecutive cycles, and `vga_rgb` stays 0 for the first `PIPE_DELAY`+1 cycles.
- Line/frame timing: run 2 full frames -> 1344 clocks per line, 806 lines per frame. The `vga_hsync` low pulse is 136 clocks wide, starting 1048+`PIPE_DELAY`+1 clocks after `draw_x`=0. `vga_vsync` is low for 6 lines. `frame_start` fires exactly once per 1,083,264 clocks.
- Alignment: model the drawer as `pixel_rgb` = {`draw_x`[3:0], `draw_y`[3:0], 4'h5} delayed 2 cycles -> at pins, every active pixel matches the coordinate issued 3 clocks earlier. Pixel `draw_x`=1023 is visible; 1024 is 0.
- Mask: `pixel_rgb`=12'h0F0 inside the active area -> `vga_rgb`=`BG_RGB`. Inputs 12'h0F1 and 12'hABC pass through unchanged.
- Blanking and `vblank`: `pixel_rgb`=12'hFFF constant -> `vga_rgb`=0 throughout the porches and lines 768..805. `vblank` rises at `draw_y`=768 and falls at `draw_y`=0.
- Mid-frame reset: assert `rst_n` low at (500, 300) during active video -> outputs go to reset values within the same cycle. After release, the scan restarts at (0, 0), and there is no `frame_start` until the next wrap.

Source files
------------

// File: rtl/vga_scan_out.sv
// rtl/vga_scan_out.sv - VGA scan generator and output stage
//
// Runs free horizontal/vertical counters on pixclk, broadcasts them to the
// draw pipeline and drives the VGA pins. The colour that comes back from
// the pipeline is aligned with sync and blanking that have been delayed by
// the same number of clocks.
//
// Ports:
//   pixclk       in   1   pixel clock
//   rst_n        in   1   asynchronous active-low reset
//   pixel_rgb    in  12   composited colour for coordinates issued PIPE_DELAY clocks earlier
//   draw_x       out 11   horizontal count, 0..H_TOTAL-1
//   draw_y       out 10   vertical count, 0..V_TOTAL-1
//   vga_rgb      out 12   pin colour, 0 when blanked
//   vga_hsync    out  1   horizontal sync, active low
//   vga_vsync    out  1   vertical sync, active low
//   vblank       out  1   high while draw_y >= V_ACTIVE
//   frame_start  out  1   one-cycle pulse on frame wrap
module vga_scan_out #(
  parameter int          H_ACTIVE   = 1024,
  parameter int          H_FP       = 24,
  parameter int          H_SYNC     = 136,
  parameter int          H_BP       = 160,
  parameter int          V_ACTIVE   = 768,
  parameter int          V_FP       = 3,
  parameter int          V_SYNC     = 6,
  parameter int          V_BP       = 29,
  parameter int          PIPE_DELAY = 2,
  parameter logic [11:0] MASK_RGB   = 12'h0F0,
  parameter logic [11:0] BG_RGB     = 12'h000
) (
  input  logic        pixclk,
  input  logic        rst_n,
  input  logic [11:0] pixel_rgb,
  output logic [10:0] draw_x,
  output logic [9:0]  draw_y,
  output logic [11:0] vga_rgb,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vblank,
  output logic        frame_start
);

  // Timing points, precomputed in the native counter widths.
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] H_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

  localparam logic [9:0]  V_ACT_END = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic        x_last;
  logic        y_last;
  logic [10:0] x_next;
  logic [9:0]  y_next;

  logic        hs_raw;
  logic        vs_raw;
  logic        act_raw;

  // Delay lines; index PIPE_DELAY-1 is the tap aligned with pixel_rgb.
  logic [PIPE_DELAY-1:0] hs_pipe;
  logic [PIPE_DELAY-1:0] vs_pipe;
  logic [PIPE_DELAY-1:0] act_pipe;

  // ------------------------------------------------------------------
  // Counter next-state
  // ------------------------------------------------------------------
  always_comb begin
    x_last = (draw_x == H_LAST);
    y_last = (draw_y == V_LAST);
    x_next = x_last ? 11'd0 : draw_x + 11'd1;
    y_next = draw_y;
    if (x_last) begin
      y_next = y_last ? 10'd0 : draw_y + 10'd1;
    end
  end

  // vblank and frame_start are derived from the next counter values so
  // that they line up with the counters rather than trailing them.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      draw_x      <= 11'd0;
      draw_y      <= 10'd0;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      draw_x      <= x_next;
      draw_y      <= y_next;
      vblank      <= (y_next >= V_ACT_END);
      frame_start <= x_last && y_last;
    end
  end

  // ------------------------------------------------------------------
  // Raw sync / active terms from the current counters
  // ------------------------------------------------------------------
  always_comb begin
    hs_raw  = !((draw_x >= HS_START) && (draw_x <= HS_END));
    vs_raw  = !((draw_y >= VS_START) && (draw_y <= VS_END));
    act_raw = (draw_x < H_ACT_END) && (draw_y < V_ACT_END);
  end

  // ------------------------------------------------------------------
  // Latency-matching delay lines
  // ------------------------------------------------------------------
  // Written as a loop so that PIPE_DELAY = 1 needs no special case.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      hs_pipe  <= '1;
      vs_pipe  <= '1;
      act_pipe <= '0;
    end else begin
      hs_pipe[0]  <= hs_raw;
      vs_pipe[0]  <= vs_raw;
      act_pipe[0] <= act_raw;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
        act_pipe[i] <= act_pipe[i-1];
      end
    end
  end

  // ------------------------------------------------------------------
  // Pin register
  // ------------------------------------------------------------------
  // The mask colour is the sprite transparency key; anything that
  // survives compositing with that value shows the background instead.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      vga_rgb   <= 12'h000;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
    end else begin
      if (act_pipe[PIPE_DELAY-1]) begin
        vga_rgb <= (pixel_rgb == MASK_RGB) ? BG_RGB : pixel_rgb;
      end else begin
        vga_rgb <= 12'h000;
      end
      vga_hsync <= hs_pipe[PIPE_DELAY-1];
      vga_vsync <= vs_pipe[PIPE_DELAY-1];
    end
  end

endmodule

// File: tb/tb_vga_scan_out.sv
// tb/tb_vga_scan_out.sv - randomized model-checked bench for vga_scan_out
module tb_vga_scan_out;

  // Reduced timing so that several complete frames fit in a short run.
  localparam int S_HA = 16, S_HFP = 2, S_HS = 4, S_HB = 6;
  localparam int S_VA = 10, S_VFP = 2, S_VS = 3, S_VB = 4;
  // Full XGA timing for the line-level boundaries.
  localparam int D_HA = 1024, D_HFP = 24, D_HS = 136, D_HB = 160;
  localparam int D_VA = 768,  D_VFP = 3,  D_VS = 6,   D_VB = 29;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] pixel_rgb;

  logic [10:0] d_x, s_x;
  logic [9:0]  d_y, s_y;
  logic [11:0] d_rgb, s_rgb;
  logic        d_hs, d_vs, d_vb, d_fs;
  logic        s_hs, s_vs, s_vb, s_fs;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] col_hist [8];

  always #5 clk = ~clk;

  vga_scan_out u_dflt (
    .pixclk(clk), .rst_n(rst_n), .pixel_rgb(pixel_rgb),
    .draw_x(d_x), .draw_y(d_y), .vga_rgb(d_rgb), .vga_hsync(d_hs),
    .vga_vsync(d_vs), .vblank(d_vb), .frame_start(d_fs)
  );

  vga_scan_out #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VB)
  ) u_small (
    .pixclk(clk), .rst_n(rst_n), .pixel_rgb(pixel_rgb),
    .draw_x(s_x), .draw_y(s_y), .vga_rgb(s_rgb), .vga_hsync(s_hs),
    .vga_vsync(s_vs), .vblank(s_vb), .frame_start(s_fs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] pick_color();
    case ($urandom_range(0, 7))
      0, 1:    return 12'h0F0;
      2:       return 12'h0F1;
      3:       return 12'hABC;
      4:       return 12'hFFF;
      default: return 12'($urandom);
    endcase
  endfunction

  // k = clocks since reset release (k = 0 is also the in-reset state).
  // Counters show scan position k; pins show position k-LAT.
  task automatic check_pins(input string who, input int k,
                            input int ha, input int hfp, input int hs, input int hb,
                            input int va, input int vfp, input int vs, input int vb,
                            input logic [10:0] ox, input logic [9:0] oy,
                            input logic [11:0] orgb, input logic ohs, input logic ovs,
                            input logic ovb, input logic ofs);
    int ht, vt, x, y, m, mx, my;
    logic [11:0] col, e_rgb;
    logic e_hs, e_vs;
    ht = ha + hfp + hs + hb;
    vt = va + vfp + vs + vb;
    x  = k % ht;
    y  = (k / ht) % vt;
    check({who, ".draw_x"}, 32'(ox), 32'(x));
    check({who, ".draw_y"}, 32'(oy), 32'(y));
    check({who, ".vblank"}, 32'(ovb), 32'(y >= va));
    check({who, ".frame_start"}, 32'(ofs), 32'((k > 0) && (k % (ht * vt) == 0)));
    m = k - LAT;
    if (m < 0) begin
      e_rgb = 12'h000;
      e_hs  = 1'b1;
      e_vs  = 1'b1;
    end else begin
      mx  = m % ht;
      my  = (m / ht) % vt;
      col = col_hist[m % 8];
      e_rgb = ((mx < ha) && (my < va)) ? ((col == 12'h0F0) ? 12'h000 : col) : 12'h000;
      e_hs  = !((mx >= ha + hfp) && (mx < ha + hfp + hs));
      e_vs  = !((my >= va + vfp) && (my < va + vfp + vs));
    end
    check({who, ".vga_rgb"}, 32'(orgb), 32'(e_rgb));
    check({who, ".vga_hsync"}, 32'(ohs), 32'(e_hs));
    check({who, ".vga_vsync"}, 32'(ovs), 32'(e_vs));
  endtask

  task automatic check_both(input int k);
    check_pins("dflt", k, D_HA, D_HFP, D_HS, D_HB, D_VA, D_VFP, D_VS, D_VB,
               d_x, d_y, d_rgb, d_hs, d_vs, d_vb, d_fs);
    check_pins("small", k, S_HA, S_HFP, S_HS, S_HB, S_VA, S_VFP, S_VS, S_VB,
               s_x, s_y, s_rgb, s_hs, s_vs, s_vb, s_fs);
  endtask

  // Called right after reset release; acts as the draw pipeline, feeding
  // back the colour chosen for the position issued two clocks earlier.
  task automatic run_phase(input int ncyc);
    col_hist[0] = pick_color();
    check_both(0);
    pixel_rgb = 12'($urandom);
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      #1;
      col_hist[k % 8] = pick_color();
      check_both(k);
      if (k >= 2) pixel_rgb = col_hist[(k - 2) % 8];
      else        pixel_rgb = 12'($urandom);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    pixel_rgb = 12'hFFF;
    for (int i = 0; i < 8; i++) col_hist[i] = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    check_both(0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ends with the small scan at (5, 3), inside active video.
    run_phase(6473);

    #2;
    rst_n = 1'b0;
    #1;
    check_both(0);
    repeat (2) @(posedge clk);
    #1;
    check_both(0);
    @(negedge clk);
    rst_n = 1'b1;

    run_phase(1200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
